// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen : program-counter generator for the RISC-V fetch stage.
//
// Produces the fetch address and a valid flag for the instruction memory.
// After reset it spends one BOOT cycle with fetch_valid low, then runs.
// In RUN the PC either takes a redirect (trap, mret, taken branch, jal,
// jalr, in that priority) or steps sequentially when the fetch handshake
// completes and the pipeline is not stalled. A misaligned branch/jal/jalr
// target parks the generator in FAULT until a trap arrives.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   stall          holds the sequential PC (redirects still apply)
//   fetch_ready    instruction memory accepts pc_out
//   fetch_valid    pc_out is a valid fetch address
//   pc_out         current fetch address
//   inst_is_16     current instruction is compressed (C_EXT=1 only)
//   branch/branch_res/branch_add   conditional branch request and target
//   jal/jal_add    jal request and target
//   jalr/jalr_add  jalr request and target (bit 0 cleared internally)
//   trap/trap_vec  trap request and handler address (bits [1:0] cleared)
//   mret/mepc_in   trap return request and return address
//   misalign_fault sticky flag for a misaligned redirect target
//   fault_addr     the offending target of the last fault
//   redirect_cnt   saturating count of redirects taken
// ---------------------------------------------------------------------------
module pc_gen #(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter int               C_EXT        = 0,
   parameter int               CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             fetch_ready,
   output logic             fetch_valid,
   output logic [XLEN-1:0]  pc_out,
   input  logic             inst_is_16,
   input  logic             branch,
   input  logic             branch_res,
   input  logic [XLEN-1:0]  branch_add,
   input  logic             jal,
   input  logic [XLEN-1:0]  jal_add,
   input  logic             jalr,
   input  logic [XLEN-1:0]  jalr_add,
   input  logic             trap,
   input  logic [XLEN-1:0]  trap_vec,
   input  logic             mret,
   input  logic [XLEN-1:0]  mepc_in,
   output logic             misalign_fault,
   output logic [XLEN-1:0]  fault_addr,
   output logic [CNT_W-1:0] redirect_cnt
);

   // Low address bits that must be zero for a legal instruction address.
   localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? XLEN'(1) : XLEN'(3);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FAULT
   } state_t;

   state_t            state, state_nxt;
   logic [XLEN-1:0]   pc_nxt;
   logic              fault_nxt;
   logic [XLEN-1:0]   fault_addr_nxt;
   logic [CNT_W-1:0]  cnt_nxt;

   logic [XLEN-1:0]   trap_tgt;
   logic [XLEN-1:0]   mret_tgt;
   logic [XLEN-1:0]   ctl_tgt;
   logic              branch_taken;
   logic              ctl_req;
   logic              ctl_misaligned;
   logic [XLEN-1:0]   seq_step;
   logic [CNT_W-1:0]  cnt_inc;

   // Target preparation. trap and mret targets are forced aligned so they
   // can never fault; branch/jal/jalr share one alignment check because
   // only the highest-priority one of them can be applied in a cycle.
   always_comb begin
      trap_tgt       = trap_vec & ~XLEN'(3);
      mret_tgt       = mepc_in & ~ALIGN_MASK;
      branch_taken   = branch && branch_res;
      ctl_req        = branch_taken || jal || jalr;
      if (branch_taken) begin
         ctl_tgt = branch_add;
      end else if (jal) begin
         ctl_tgt = jal_add;
      end else begin
         ctl_tgt = jalr_add & ~XLEN'(1);
      end
      ctl_misaligned = (ctl_tgt & ALIGN_MASK) != '0;
      seq_step       = ((C_EXT != 0) && inst_is_16) ? XLEN'(2) : XLEN'(4);
      cnt_inc        = (redirect_cnt == '1) ? redirect_cnt : redirect_cnt + CNT_W'(1);
   end

   // State and datapath registers; reset returns everything to the
   // power-on values immediately, whatever state we were in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= BOOT;
         pc_out         <= RESET_VECTOR;
         misalign_fault <= 1'b0;
         fault_addr     <= '0;
         redirect_cnt   <= '0;
      end else begin
         state          <= state_nxt;
         pc_out         <= pc_nxt;
         misalign_fault <= fault_nxt;
         fault_addr     <= fault_addr_nxt;
         redirect_cnt   <= cnt_nxt;
      end
   end

   // Next-state and next-PC selection. Redirects ignore stall and
   // fetch_ready; the sequential step needs a completed handshake.
   // In FAULT only a trap is honoured, and it clears the fault.
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc_out;
      fault_nxt      = misalign_fault;
      fault_addr_nxt = fault_addr;
      cnt_nxt        = redirect_cnt;
      case (state)
         BOOT: begin
            state_nxt = RUN;
         end
         RUN: begin
            if (trap) begin
               pc_nxt  = trap_tgt;
               cnt_nxt = cnt_inc;
            end else if (mret) begin
               pc_nxt  = mret_tgt;
               cnt_nxt = cnt_inc;
            end else if (ctl_req) begin
               if (ctl_misaligned) begin
                  state_nxt      = FAULT;
                  fault_nxt      = 1'b1;
                  fault_addr_nxt = ctl_tgt;
               end else begin
                  pc_nxt  = ctl_tgt;
                  cnt_nxt = cnt_inc;
               end
            end else if (fetch_valid && fetch_ready && !stall) begin
               pc_nxt = pc_out + seq_step;
            end
         end
         FAULT: begin
            if (trap) begin
               state_nxt = RUN;
               pc_nxt    = trap_tgt;
               fault_nxt = 1'b0;
               cnt_nxt   = cnt_inc;
            end
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   // Fetch addresses are only offered while running.
   always_comb begin
      fetch_valid = (state == RUN);
   end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen : self-checking bench for pc_gen.
//
// Two instances share clk and rst: dut (C_EXT=0, RESET_VECTOR=0x100,
// CNT_W=2) covers boot, stepping, stall, priority, faults, wrap and
// saturation; dut_c (C_EXT=1) covers compressed stepping and 2-byte
// alignment. Each step's expected outputs are pushed to a scoreboard
// queue when its stimulus is driven and popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_pc_gen;

   typedef struct packed {
      logic        stall;
      logic        ready;
      logic        is16;
      logic        br;
      logic        br_res;
      logic        jal;
      logic        jalr;
      logic        trap;
      logic        mret;
      logic [31:0] br_add;
      logic [31:0] jal_add;
      logic [31:0] jalr_add;
      logic [31:0] trap_vec;
      logic [31:0] mepc;
   } stim_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        fv;
      logic        mf;
      logic [31:0] fa;
      logic [15:0] cnt;
   } exp_t;

   int checks   = 0;
   int failures = 0;
   exp_t sb[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        stall = 1'b0, fetch_ready = 1'b0, inst_is_16 = 1'b0;
   logic        branch = 1'b0, branch_res = 1'b0, jal = 1'b0, jalr = 1'b0;
   logic        trap = 1'b0, mret = 1'b0;
   logic [31:0] branch_add = '0, jal_add = '0, jalr_add = '0, trap_vec = '0, mepc_in = '0;
   logic        fetch_valid, misalign_fault;
   logic [31:0] pc_out, fault_addr;
   logic [1:0]  redirect_cnt;

   logic        c_stall = 1'b0, c_fetch_ready = 1'b0, c_inst_is_16 = 1'b0;
   logic        c_branch = 1'b0, c_branch_res = 1'b0, c_jal = 1'b0, c_jalr = 1'b0;
   logic        c_trap = 1'b0, c_mret = 1'b0;
   logic [31:0] c_branch_add = '0, c_jal_add = '0, c_jalr_add = '0, c_trap_vec = '0, c_mepc_in = '0;
   logic        c_fetch_valid, c_misalign_fault;
   logic [31:0] c_pc_out, c_fault_addr;
   logic [15:0] c_redirect_cnt;

   always #5 clk = ~clk;

   pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .C_EXT(0), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .pc_out(pc_out), .inst_is_16(inst_is_16),
      .branch(branch), .branch_res(branch_res), .branch_add(branch_add),
      .jal(jal), .jal_add(jal_add), .jalr(jalr), .jalr_add(jalr_add),
      .trap(trap), .trap_vec(trap_vec), .mret(mret), .mepc_in(mepc_in),
      .misalign_fault(misalign_fault), .fault_addr(fault_addr),
      .redirect_cnt(redirect_cnt)
   );

   pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1), .CNT_W(16)) dut_c (
      .clk(clk), .rst(rst), .stall(c_stall), .fetch_ready(c_fetch_ready),
      .fetch_valid(c_fetch_valid), .pc_out(c_pc_out), .inst_is_16(c_inst_is_16),
      .branch(c_branch), .branch_res(c_branch_res), .branch_add(c_branch_add),
      .jal(c_jal), .jal_add(c_jal_add), .jalr(c_jalr), .jalr_add(c_jalr_add),
      .trap(c_trap), .trap_vec(c_trap_vec), .mret(c_mret), .mepc_in(c_mepc_in),
      .misalign_fault(c_misalign_fault), .fault_addr(c_fault_addr),
      .redirect_cnt(c_redirect_cnt)
   );

   function automatic stim_t idle(input logic ready);
      stim_t s;
      s = '0;
      s.ready = ready;
      return s;
   endfunction

   function automatic exp_t mk(input logic [31:0] pc, input logic fv, input logic mf,
                               input logic [31:0] fa, input logic [15:0] cnt);
      exp_t e;
      e.pc = pc; e.fv = fv; e.mf = mf; e.fa = fa; e.cnt = cnt;
      return e;
   endfunction

   task automatic apply_stim(input stim_t s);
      stall = s.stall; fetch_ready = s.ready; inst_is_16 = s.is16;
      branch = s.br; branch_res = s.br_res; branch_add = s.br_add;
      jal = s.jal; jal_add = s.jal_add; jalr = s.jalr; jalr_add = s.jalr_add;
      trap = s.trap; trap_vec = s.trap_vec; mret = s.mret; mepc_in = s.mepc;
   endtask

   task automatic apply_stim_c(input stim_t s);
      c_stall = s.stall; c_fetch_ready = s.ready; c_inst_is_16 = s.is16;
      c_branch = s.br; c_branch_res = s.br_res; c_branch_add = s.br_add;
      c_jal = s.jal; c_jal_add = s.jal_add; c_jalr = s.jalr; c_jalr_add = s.jalr_add;
      c_trap = s.trap; c_trap_vec = s.trap_vec; c_mret = s.mret; c_mepc_in = s.mepc;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      apply_stim(idle(1'b1));
      repeat (2) @(posedge clk);
      #1;
      checks += 6;
      if (pc_out !== 32'h100) begin failures++; $display("[TB] FAIL reset pc_out got %h expected %h", pc_out, 32'h100); end
      if (fetch_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset fetch_valid got %b expected 0", fetch_valid); end
      if (misalign_fault !== 1'b0) begin failures++; $display("[TB] FAIL reset misalign_fault got %b expected 0", misalign_fault); end
      if (fault_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset fault_addr got %h expected 0", fault_addr); end
      if (redirect_cnt !== 2'd0) begin failures++; $display("[TB] FAIL reset redirect_cnt got %0d expected 0", redirect_cnt); end
      if (c_pc_out !== 32'h0) begin failures++; $display("[TB] FAIL reset c_pc_out got %h expected 0", c_pc_out); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks += 2;
      if (fetch_valid !== 1'b0) begin failures++; $display("[TB] FAIL boot fetch_valid got %b expected 0", fetch_valid); end
      if (pc_out !== 32'h100) begin failures++; $display("[TB] FAIL boot pc_out got %h expected %h", pc_out, 32'h100); end
   endtask

   // Boot, handshake hold, stall hold, inst_is_16 ignored, walk to 0x200.
   task automatic test_sequential();
      stim_t st[$];
      exp_t  ex[$];
      stim_t s;
      exp_t  e;
      st.push_back(idle(1'b1)); ex.push_back(mk(32'h100, 1, 0, 0, 0));
      st.push_back(idle(1'b1)); ex.push_back(mk(32'h104, 1, 0, 0, 0));
      st.push_back(idle(1'b1)); ex.push_back(mk(32'h108, 1, 0, 0, 0));
      st.push_back(idle(1'b0)); ex.push_back(mk(32'h108, 1, 0, 0, 0));
      s = idle(1'b1); s.stall = 1'b1;
      st.push_back(s);          ex.push_back(mk(32'h108, 1, 0, 0, 0));
      s = idle(1'b1); s.is16 = 1'b1;
      st.push_back(s);          ex.push_back(mk(32'h10C, 1, 0, 0, 0));
      for (int k = 1; k <= 61; k++) begin
         st.push_back(idle(1'b1)); ex.push_back(mk(32'h10C + 32'(4 * k), 1, 0, 0, 0));
      end
      for (int i = 0; i < st.size(); i++) begin
         apply_stim(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks += 5;
         if (pc_out !== e.pc) begin failures++; $display("[TB] FAIL seq pc_out step %0d got %h expected %h", i, pc_out, e.pc); end
         if (fetch_valid !== e.fv) begin failures++; $display("[TB] FAIL seq fetch_valid step %0d got %b expected %b", i, fetch_valid, e.fv); end
         if (misalign_fault !== e.mf) begin failures++; $display("[TB] FAIL seq misalign_fault step %0d got %b expected %b", i, misalign_fault, e.mf); end
         if (fault_addr !== e.fa) begin failures++; $display("[TB] FAIL seq fault_addr step %0d got %h expected %h", i, fault_addr, e.fa); end
         if ({14'b0, redirect_cnt} !== e.cnt) begin failures++; $display("[TB] FAIL seq redirect_cnt step %0d got %0d expected %0d", i, redirect_cnt, e.cnt); end
      end
   endtask

   // Stall with redirect, priority among sources, counter saturation.
   task automatic test_redirects();
      stim_t st[$];
      exp_t  ex[$];
      stim_t s;
      exp_t  e;
      s = idle(1'b1); s.stall = 1'b1;
      repeat (3) begin st.push_back(s); ex.push_back(mk(32'h200, 1, 0, 0, 0)); end
      s.jal = 1'b1; s.jal_add = 32'h400;
      st.push_back(s); ex.push_back(mk(32'h400, 1, 0, 0, 1));
      s = idle(1'b1); s.stall = 1'b1;
      st.push_back(s); ex.push_back(mk(32'h400, 1, 0, 0, 1));
      st.push_back(idle(1'b1)); ex.push_back(mk(32'h404, 1, 0, 0, 1));
      s = idle(1'b1); s.br = 1'b1; s.br_res = 1'b1; s.br_add = 32'h80; s.jal = 1'b1; s.jal_add = 32'h90;
      st.push_back(s); ex.push_back(mk(32'h80, 1, 0, 0, 2));
      s.trap = 1'b1; s.trap_vec = 32'h1003;
      st.push_back(s); ex.push_back(mk(32'h1000, 1, 0, 0, 3));
      s = idle(1'b1); s.br = 1'b1; s.br_res = 1'b0; s.br_add = 32'h80; s.jal = 1'b1; s.jal_add = 32'h90;
      st.push_back(s); ex.push_back(mk(32'h90, 1, 0, 0, 3));
      s = idle(1'b1); s.mret = 1'b1; s.mepc = 32'h503;
      st.push_back(s); ex.push_back(mk(32'h500, 1, 0, 0, 3));
      s = idle(1'b0); s.stall = 1'b1; s.jalr = 1'b1; s.jalr_add = 32'h605;
      st.push_back(s); ex.push_back(mk(32'h604, 1, 0, 0, 3));
      s = idle(1'b1); s.mret = 1'b1; s.mepc = 32'h703; s.br = 1'b1; s.br_res = 1'b1; s.br_add = 32'h80;
      st.push_back(s); ex.push_back(mk(32'h700, 1, 0, 0, 3));
      for (int i = 0; i < st.size(); i++) begin
         apply_stim(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks += 5;
         if (pc_out !== e.pc) begin failures++; $display("[TB] FAIL redir pc_out step %0d got %h expected %h", i, pc_out, e.pc); end
         if (fetch_valid !== e.fv) begin failures++; $display("[TB] FAIL redir fetch_valid step %0d got %b expected %b", i, fetch_valid, e.fv); end
         if (misalign_fault !== e.mf) begin failures++; $display("[TB] FAIL redir misalign_fault step %0d got %b expected %b", i, misalign_fault, e.mf); end
         if (fault_addr !== e.fa) begin failures++; $display("[TB] FAIL redir fault_addr step %0d got %h expected %h", i, fault_addr, e.fa); end
         if ({14'b0, redirect_cnt} !== e.cnt) begin failures++; $display("[TB] FAIL redir redirect_cnt step %0d got %0d expected %0d", i, redirect_cnt, e.cnt); end
      end
   endtask

   // Misaligned jal, ignored requests in FAULT, trap recovery, PC wrap.
   task automatic test_fault_wrap();
      stim_t st[$];
      exp_t  ex[$];
      stim_t s;
      exp_t  e;
      s = idle(1'b1); s.jal = 1'b1; s.jal_add = 32'h302;
      st.push_back(s); ex.push_back(mk(32'h700, 0, 1, 32'h302, 3));
      s.jal_add = 32'h900;
      st.push_back(s); ex.push_back(mk(32'h700, 0, 1, 32'h302, 3));
      s = idle(1'b1); s.br = 1'b1; s.br_res = 1'b1; s.br_add = 32'h80;
      st.push_back(s); ex.push_back(mk(32'h700, 0, 1, 32'h302, 3));
      s = idle(1'b1); s.mret = 1'b1; s.mepc = 32'h10;
      st.push_back(s); ex.push_back(mk(32'h700, 0, 1, 32'h302, 3));
      st.push_back(idle(1'b1)); ex.push_back(mk(32'h700, 0, 1, 32'h302, 3));
      s = idle(1'b1); s.trap = 1'b1; s.trap_vec = 32'h40;
      st.push_back(s); ex.push_back(mk(32'h40, 1, 0, 32'h302, 3));
      st.push_back(idle(1'b1)); ex.push_back(mk(32'h44, 1, 0, 32'h302, 3));
      s = idle(1'b1); s.jal = 1'b1; s.jal_add = 32'hFFFF_FFFC;
      st.push_back(s); ex.push_back(mk(32'hFFFF_FFFC, 1, 0, 32'h302, 3));
      st.push_back(idle(1'b1)); ex.push_back(mk(32'h0, 1, 0, 32'h302, 3));
      st.push_back(idle(1'b1)); ex.push_back(mk(32'h4, 1, 0, 32'h302, 3));
      s = idle(1'b1); s.jalr = 1'b1; s.jalr_add = 32'h3;
      st.push_back(s); ex.push_back(mk(32'h4, 0, 1, 32'h2, 3));
      for (int i = 0; i < st.size(); i++) begin
         apply_stim(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks += 5;
         if (pc_out !== e.pc) begin failures++; $display("[TB] FAIL fault pc_out step %0d got %h expected %h", i, pc_out, e.pc); end
         if (fetch_valid !== e.fv) begin failures++; $display("[TB] FAIL fault fetch_valid step %0d got %b expected %b", i, fetch_valid, e.fv); end
         if (misalign_fault !== e.mf) begin failures++; $display("[TB] FAIL fault misalign_fault step %0d got %b expected %b", i, misalign_fault, e.mf); end
         if (fault_addr !== e.fa) begin failures++; $display("[TB] FAIL fault fault_addr step %0d got %h expected %h", i, fault_addr, e.fa); end
         if ({14'b0, redirect_cnt} !== e.cnt) begin failures++; $display("[TB] FAIL fault redirect_cnt step %0d got %0d expected %0d", i, redirect_cnt, e.cnt); end
      end
   endtask

   // Asynchronous reset while parked in FAULT, then a fresh boot.
   task automatic test_reset_mid_fault();
      exp_t e;
      apply_stim(idle(1'b1));
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks += 6;
      if (pc_out !== 32'h100) begin failures++; $display("[TB] FAIL midrst pc_out got %h expected %h", pc_out, 32'h100); end
      if (fetch_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst fetch_valid got %b expected 0", fetch_valid); end
      if (misalign_fault !== 1'b0) begin failures++; $display("[TB] FAIL midrst misalign_fault got %b expected 0", misalign_fault); end
      if (fault_addr !== 32'h0) begin failures++; $display("[TB] FAIL midrst fault_addr got %h expected 0", fault_addr); end
      if (redirect_cnt !== 2'd0) begin failures++; $display("[TB] FAIL midrst redirect_cnt got %0d expected 0", redirect_cnt); end
      if (c_pc_out !== 32'h0) begin failures++; $display("[TB] FAIL midrst c_pc_out got %h expected 0", c_pc_out); end
      @(negedge clk);
      rst = 1'b1;
      sb.push_back(mk(32'h100, 1, 0, 0, 0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks += 4;
      if (pc_out !== e.pc) begin failures++; $display("[TB] FAIL midrst boot pc_out got %h expected %h", pc_out, e.pc); end
      if (fetch_valid !== e.fv) begin failures++; $display("[TB] FAIL midrst boot fetch_valid got %b expected %b", fetch_valid, e.fv); end
      if (fault_addr !== e.fa) begin failures++; $display("[TB] FAIL midrst boot fault_addr got %h expected %h", fault_addr, e.fa); end
      if ({14'b0, redirect_cnt} !== e.cnt) begin failures++; $display("[TB] FAIL midrst boot redirect_cnt got %0d expected %0d", redirect_cnt, e.cnt); end
   endtask

   // Compressed stepping and 2-byte alignment on the C_EXT=1 instance.
   task automatic test_compressed();
      stim_t st[$];
      exp_t  ex[$];
      stim_t s;
      exp_t  e;
      s = idle(1'b0); s.jal = 1'b1; s.jal_add = 32'h10;
      st.push_back(s); ex.push_back(mk(32'h10, 1, 0, 0, 1));
      s = idle(1'b1); s.is16 = 1'b1;
      st.push_back(s); ex.push_back(mk(32'h12, 1, 0, 0, 1));
      st.push_back(idle(1'b1)); ex.push_back(mk(32'h16, 1, 0, 0, 1));
      s = idle(1'b1); s.jalr = 1'b1; s.jalr_add = 32'h21;
      st.push_back(s); ex.push_back(mk(32'h20, 1, 0, 0, 2));
      s = idle(1'b1); s.jal = 1'b1; s.jal_add = 32'h32;
      st.push_back(s); ex.push_back(mk(32'h32, 1, 0, 0, 3));
      s = idle(1'b1); s.is16 = 1'b1;
      st.push_back(s); ex.push_back(mk(32'h34, 1, 0, 0, 3));
      s = idle(1'b1); s.br = 1'b1; s.br_res = 1'b1; s.br_add = 32'h35;
      st.push_back(s); ex.push_back(mk(32'h34, 0, 1, 32'h35, 3));
      s = idle(1'b1); s.trap = 1'b1; s.trap_vec = 32'h42;
      st.push_back(s); ex.push_back(mk(32'h40, 1, 0, 32'h35, 4));
      for (int i = 0; i < st.size(); i++) begin
         apply_stim_c(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks += 5;
         if (c_pc_out !== e.pc) begin failures++; $display("[TB] FAIL cext pc_out step %0d got %h expected %h", i, c_pc_out, e.pc); end
         if (c_fetch_valid !== e.fv) begin failures++; $display("[TB] FAIL cext fetch_valid step %0d got %b expected %b", i, c_fetch_valid, e.fv); end
         if (c_misalign_fault !== e.mf) begin failures++; $display("[TB] FAIL cext misalign_fault step %0d got %b expected %b", i, c_misalign_fault, e.mf); end
         if (c_fault_addr !== e.fa) begin failures++; $display("[TB] FAIL cext fault_addr step %0d got %h expected %h", i, c_fault_addr, e.fa); end
         if (c_redirect_cnt !== e.cnt) begin failures++; $display("[TB] FAIL cext redirect_cnt step %0d got %0d expected %0d", i, c_redirect_cnt, e.cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_redirects();
      test_fault_wrap();
      test_reset_mid_fault();
      test_compressed();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
